// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared types and constants for the raster scanner
package raster_pkg;

  localparam int PKG_FRAC_BITS = 8;
  localparam int PKG_INT_BITS  = 9;
  localparam int PKG_W         = PKG_INT_BITS + PKG_FRAC_BITS;

  typedef logic [PKG_W-1:0]      coord_t;
  typedef logic [PKG_INT_BITS:0] pixel_t;

  typedef struct packed {
    pixel_t xmin;
    pixel_t xmax;
    pixel_t ymin;
    pixel_t ymax;
  } bbox_t;

  typedef enum logic [1:0] {IDLE, BOUND, SCAN} scan_state_t;

  function automatic int half_pixel(input int frac_bits);
    return 1 << (frac_bits - 1);
  endfunction

  localparam coord_t HALF_PIXEL = coord_t'(half_pixel(PKG_FRAC_BITS));

endpackage

// File: rtl/raster_scanner_if.sv
// rtl/raster_scanner_if.sv - triangle input and sample-beat output bundle
interface raster_scanner_if #(
  parameter int FRAC_BITS = 8,
  parameter int INT_BITS  = 9,
  parameter int LANES     = 4
);
  localparam int W = INT_BITS + FRAC_BITS;

  logic                          valid_in;
  logic                          ready_out;
  logic [2:0][1:0][W-1:0]        vertices_in;
  logic [W-1:0]                  z_in;
  logic [11:0]                   color_in;
  logic                          scissor_en_in;
  logic [3:0][INT_BITS-1:0]      scissor_in;
  logic                          valid_out;
  logic                          ready_in;
  logic [LANES-1:0][1:0][W-1:0]  points_out;
  logic [LANES-1:0]              lane_mask_out;
  logic [W-1:0]                  z_out;
  logic [11:0]                   color_out;
  logic [15:0]                   triangle_id_out;
  logic                          last_out;

  modport master (
    output valid_in, vertices_in, z_in, color_in, scissor_en_in, scissor_in, ready_in,
    input  ready_out, valid_out, points_out, lane_mask_out, z_out, color_out,
           triangle_id_out, last_out
  );

  modport slave (
    input  valid_in, vertices_in, z_in, color_in, scissor_en_in, scissor_in, ready_in,
    output ready_out, valid_out, points_out, lane_mask_out, z_out, color_out,
           triangle_id_out, last_out
  );

endinterface

// File: rtl/bbox_unit.sv
// rtl/bbox_unit.sv - clamped, scissored pixel bounding box of a triangle
module bbox_unit #(
  parameter int INT_BITS = 9,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  localparam int PW      = INT_BITS + 1
) (
  input  logic [2:0][1:0][INT_BITS-1:0] vint,
  input  logic                          scissor_en,
  input  logic [3:0][INT_BITS-1:0]      scissor,
  output logic [PW-1:0]                 xmin,
  output logic [PW-1:0]                 xmax,
  output logic [PW-1:0]                 ymin,
  output logic [PW-1:0]                 ymax,
  output logic                          empty
);

  function automatic logic [PW-1:0] min2(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [PW-1:0] max2(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [PW-1:0] vx0, vx1, vx2, vy0, vy1, vy2;

  assign vx0 = {1'b0, vint[0][0]};
  assign vx1 = {1'b0, vint[1][0]};
  assign vx2 = {1'b0, vint[2][0]};
  assign vy0 = {1'b0, vint[0][1]};
  assign vy1 = {1'b0, vint[1][1]};
  assign vy2 = {1'b0, vint[2][1]};

  always_comb begin
    xmin = min2(min2(vx0, vx1), vx2);
    ymin = min2(min2(vy0, vy1), vy2);
    xmax = min2(max2(max2(vx0, vx1), vx2), PW'(SCREEN_W - 1));
    ymax = min2(max2(max2(vy0, vy1), vy2), PW'(SCREEN_H - 1));
    // scissor word order is {x0, y0, x1, y1}, x0 in the top slot
    if (scissor_en) begin
      xmin = max2(xmin, {1'b0, scissor[3]});
      ymin = max2(ymin, {1'b0, scissor[2]});
      xmax = min2(xmax, {1'b0, scissor[1]});
      ymax = min2(ymax, {1'b0, scissor[0]});
    end
    empty = (xmin > xmax) || (ymin > ymax);
  end

endmodule

// File: rtl/raster_scanner.sv
// rtl/raster_scanner.sv - walks a triangle's bounding box emitting LANES-wide sample beats
module raster_scanner
  import raster_pkg::*;
#(
  parameter int FRAC_BITS = PKG_FRAC_BITS,
  parameter int INT_BITS  = PKG_INT_BITS,
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int LANES     = 4
) (
  input logic             clk_in,
  input logic             rst_in,
  raster_scanner_if.slave bus
);

  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int PW = INT_BITS + 1;
  localparam logic [FRAC_BITS-1:0] HALF = FRAC_BITS'(half_pixel(FRAC_BITS));

  scan_state_t state, state_nx;

  logic [2:0][1:0][INT_BITS-1:0] vint_q;
  logic                          scissor_en_q;
  logic [3:0][INT_BITS-1:0]      scissor_q;
  logic [W-1:0]                  z_q;
  logic [11:0]                   color_q;
  logic [15:0]                   id_cnt, tri_id;
  logic [PW-1:0]                 xmin_q, xmax_q, ymax_q, px, py;
  logic [PW-1:0]                 bx_min, bx_max, by_min, by_max;
  logic                          box_empty;
  logic                          accept, fire, row_end, last_beat, scanning;
  logic                          unused_frac;

  logic [LANES-1:0][1:0][W-1:0]  points;
  logic [LANES-1:0]              lane_mask;

  bbox_unit #(
    .INT_BITS (INT_BITS),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_bbox (
    .vint       (vint_q),
    .scissor_en (scissor_en_q),
    .scissor    (scissor_q),
    .xmin       (bx_min),
    .xmax       (bx_max),
    .ymin       (by_min),
    .ymax       (by_max),
    .empty      (box_empty)
  );

  assign scanning  = (state == SCAN);
  assign accept    = (state == IDLE) && bus.valid_in;
  assign fire      = scanning && bus.ready_in;
  assign row_end   = (px + PW'(LANES)) > xmax_q;
  assign last_beat = (py == ymax_q) && row_end;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.valid_in) state_nx = BOUND;
      BOUND:   state_nx = box_empty ? IDLE : SCAN;
      SCAN:    if (fire && last_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= IDLE;
      id_cnt <= '0;
      tri_id <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        tri_id <= id_cnt;
        id_cnt <= id_cnt + 16'd1;
      end
    end
  end

  // only the integer part of each vertex matters once the box is known
  always_ff @(posedge clk_in) begin
    if (accept) begin
      for (int v = 0; v < 3; v++) begin
        for (int c = 0; c < 2; c++) begin
          vint_q[v][c] <= bus.vertices_in[v][c][W-1:FRAC_BITS];
        end
      end
      z_q          <= bus.z_in;
      color_q      <= bus.color_in;
      scissor_en_q <= bus.scissor_en_in;
      scissor_q    <= bus.scissor_in;
    end
    if (state == BOUND) begin
      xmin_q <= bx_min;
      xmax_q <= bx_max;
      ymax_q <= by_max;
      px     <= bx_min;
      py     <= by_min;
    end else if (fire) begin
      if (row_end) begin
        px <= xmin_q;
        py <= py + PW'(1);
      end else begin
        px <= px + PW'(LANES);
      end
    end
  end

  always_comb begin
    points    = '0;
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      points[i][0] = {px[INT_BITS-1:0] + INT_BITS'(i), HALF};
      points[i][1] = {py[INT_BITS-1:0], HALF};
      lane_mask[i] = scanning && ((px + PW'(i)) <= xmax_q);
    end
  end

  always_comb begin
    unused_frac = 1'b0;
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < 2; c++) begin
        unused_frac = unused_frac ^ (^bus.vertices_in[v][c][FRAC_BITS-1:0]);
      end
    end
  end

  assign bus.ready_out       = (state == IDLE);
  assign bus.valid_out       = scanning;
  assign bus.last_out        = scanning && last_beat;
  assign bus.points_out      = points;
  assign bus.lane_mask_out   = lane_mask;
  assign bus.z_out           = z_q;
  assign bus.color_out       = color_q;
  assign bus.triangle_id_out = tri_id;

endmodule

// File: tb/tb_raster_scanner.sv
// tb/tb_raster_scanner.sv - randomized and directed bench for raster_scanner
module tb_raster_scanner;
  import raster_pkg::*;

  localparam int FB = 8;
  localparam int IB = 9;
  localparam int LN = 4;
  localparam int SW = 320;
  localparam int SH = 240;
  localparam int W  = FB + IB;
  localparam int PB = LN * 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  raster_scanner_if #(.FRAC_BITS(FB), .INT_BITS(IB), .LANES(LN)) bus ();

  raster_scanner #(
    .FRAC_BITS (FB),
    .INT_BITS  (IB),
    .SCREEN_W  (SW),
    .SCREEN_H  (SH),
    .LANES     (LN)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  typedef struct {
    int            px;
    int            py;
    logic [LN-1:0] mask;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec    = 0;
  int    n_err    = 0;
  int    model_id = 0;
  int    vr[3][2];
  int    sc[4];
  bit    sc_en;
  int    nb_a, nb_b;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference box: whole-pixel extent of the vertices, screen clamp on the max side, scissor overlap
  function automatic bbox_t model_box(output bit empty);
    bbox_t b;
    int x0, x1, y0, y1;
    x0 = imin(imin(vr[0][0] >> FB, vr[1][0] >> FB), vr[2][0] >> FB);
    x1 = imin(imax(imax(vr[0][0] >> FB, vr[1][0] >> FB), vr[2][0] >> FB), SW - 1);
    y0 = imin(imin(vr[0][1] >> FB, vr[1][1] >> FB), vr[2][1] >> FB);
    y1 = imin(imax(imax(vr[0][1] >> FB, vr[1][1] >> FB), vr[2][1] >> FB), SH - 1);
    if (sc_en) begin
      x0 = imax(x0, sc[0]);
      y0 = imax(y0, sc[1]);
      x1 = imin(x1, sc[2]);
      y1 = imin(y1, sc[3]);
    end
    empty  = (x0 > x1) || (y0 > y1);
    b.xmin = pixel_t'(x0);
    b.xmax = pixel_t'(x1);
    b.ymin = pixel_t'(y0);
    b.ymax = pixel_t'(y1);
    return b;
  endfunction

  task automatic build_expected(input bbox_t b);
    beat_t e;
    int xmin, xmax, ymin, ymax;
    xmin = int'(b.xmin);
    xmax = int'(b.xmax);
    ymin = int'(b.ymin);
    ymax = int'(b.ymax);
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x += LN) begin
        e.px = x;
        e.py = y;
        for (int i = 0; i < LN; i++) e.mask[i] = (x + i <= xmax);
        e.last = (y == ymax) && (x + LN > xmax);
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic logic [PB-1:0] exp_points(input int px, input int py);
    logic [LN-1:0][1:0][W-1:0] p;
    for (int i = 0; i < LN; i++) begin
      p[i][0] = coord_t'(((px + i) & ((1 << IB) - 1)) << FB) | HALF_PIXEL;
      p[i][1] = coord_t'(py << FB) | HALF_PIXEL;
    end
    return p;
  endfunction

  task automatic set_v(input int x0, input int y0, input int x1, input int y1,
                       input int x2, input int y2);
    vr[0][0] = x0; vr[0][1] = y0;
    vr[1][0] = x1; vr[1][1] = y1;
    vr[2][0] = x2; vr[2][1] = y2;
  endtask

  // mode: 0 ready always high, 1 ready toggles 1010..., 2 ready random
  task automatic run_tri(input string tag, input int mode, input int abort_after, output int nbeats);
    bbox_t          b;
    bit             empty;
    logic [W-1:0]   z;
    logic [11:0]    col;
    logic [15:0]    id;
    logic [255:0]   held;
    logic [255:0]   cur;
    bit             holding;
    bit             r;
    int             cyc;
    int             wait_cyc;
    beat_t          e;
    nbeats = 0;
    exp_q.delete();
    b = model_box(empty);
    if (!empty) build_expected(b);
    z        = W'($urandom);
    col      = 12'($urandom);
    id       = 16'(model_id);
    model_id = (model_id + 1) & 16'hFFFF;

    wait_cyc = 0;
    while (!bus.ready_out && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({tag, " ready_idle"}, 256'(bus.ready_out), 256'(1));
    bus.valid_in      = 1'b1;
    for (int v = 0; v < 3; v++) begin
      bus.vertices_in[v][0] = W'(vr[v][0]);
      bus.vertices_in[v][1] = W'(vr[v][1]);
    end
    bus.z_in          = z;
    bus.color_in      = col;
    bus.scissor_en_in = sc_en;
    bus.scissor_in    = {IB'(sc[0]), IB'(sc[1]), IB'(sc[2]), IB'(sc[3])};
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.z_in     = '0;
    check({tag, " busy"}, 256'(bus.ready_out), 256'(0));
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, " empty_valid"}, 256'(bus.valid_out), 256'(0));
      check({tag, " empty_ready"}, 256'(bus.ready_out), 256'(1));
      return;
    end
    check({tag, " latency"}, 256'(bus.valid_out), 256'(1));

    holding = 1'b0;
    cyc     = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      if (abort_after >= 0 && nbeats == abort_after) begin
        rst = 1'b1;
        #1;
        check({tag, " rst_valid"}, 256'(bus.valid_out), 256'(0));
        check({tag, " rst_mask"}, 256'(bus.lane_mask_out), 256'(0));
        check({tag, " rst_last"}, 256'(bus.last_out), 256'(0));
        check({tag, " rst_id"}, 256'(bus.triangle_id_out), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        model_id = 0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check({tag, " abandoned"}, 256'(bus.valid_out), 256'(0));
        return;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      bus.ready_in = r;
      cur = 256'({bus.points_out, bus.lane_mask_out, bus.last_out,
                  bus.z_out, bus.color_out, bus.triangle_id_out});
      if (!bus.valid_out) begin
        check({tag, " valid_hold"}, 256'(bus.valid_out), 256'(1));
        cyc = 3000;
      end else begin
        if (holding) check({tag, " stall_stable"}, cur, held);
        if (r) begin
          e = exp_q.pop_front();
          check({tag, " points"}, 256'(bus.points_out), 256'(exp_points(e.px, e.py)));
          check({tag, " mask"}, 256'(bus.lane_mask_out), 256'(e.mask));
          check({tag, " last"}, 256'(bus.last_out), 256'(e.last));
          check({tag, " meta"}, 256'({bus.z_out, bus.color_out, bus.triangle_id_out}),
                256'({z, col, id}));
          nbeats++;
          holding = 1'b0;
        end else begin
          held    = cur;
          holding = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " beats_left"}, 256'(exp_q.size()), 256'(0));
    check({tag, " done_valid"}, 256'(bus.valid_out), 256'(0));
    check({tag, " done_ready"}, 256'(bus.ready_out), 256'(1));
    bus.ready_in = 1'b1;
  endtask

  initial begin
    bus.valid_in      = 1'b0;
    bus.vertices_in   = '0;
    bus.z_in          = '0;
    bus.color_in      = '0;
    bus.scissor_en_in = 1'b0;
    bus.scissor_in    = '0;
    bus.ready_in      = 1'b1;
    sc_en = 1'b0;
    sc    = '{0, 0, 0, 0};
    repeat (2) @(negedge clk);
    check("reset ready", 256'(bus.ready_out), 256'(1));
    check("reset valid", 256'(bus.valid_out), 256'(0));
    check("reset mask", 256'(bus.lane_mask_out), 256'(0));
    check("reset last", 256'(bus.last_out), 256'(0));
    check("reset id", 256'(bus.triangle_id_out), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    set_v(10*256 + 51, 5*256 + 128, 13*256 + 230, 5*256 + 230, 11*256, 6*256 + 26);
    run_tri("two_rows", 0, -1, nb_a);
    check("two_rows count", 256'(nb_a), 256'(2));

    set_v(3*256, 0, 8*256, 0, 4*256, 0);
    run_tri("partial", 0, -1, nb_a);
    check("partial count", 256'(nb_a), 256'(2));

    set_v(400*256, 10*256, 318*256, 11*256, 318*256 + 99, 12*256);
    run_tri("clamp", 0, -1, nb_a);
    check("clamp count", 256'(nb_a), 256'(3));

    sc_en = 1'b1;
    sc    = '{0, 0, 5, 5};
    set_v(10*256, 10*256, 20*256, 20*256, 15*256, 15*256);
    run_tri("scissor_empty", 0, -1, nb_a);
    sc_en = 1'b0;

    set_v(0, 30*256, 20*256 + 7, 31*256, 9*256, 33*256 + 200);
    run_tri("run_free", 0, -1, nb_a);
    run_tri("run_stall", 1, -1, nb_b);
    check("stall count", 256'(nb_b), 256'(nb_a));

    set_v(0, 0, 100*256, 10*256, 50*256, 5*256);
    run_tri("abort", 0, 3, nb_a);
    set_v(10*256 + 51, 5*256 + 128, 13*256 + 230, 5*256 + 230, 11*256, 6*256 + 26);
    run_tri("after_rst", 0, -1, nb_a);

    for (int t = 0; t < 25; t++) begin
      int bx, by;
      bx = $urandom_range(0, 335);
      by = $urandom_range(0, 250);
      for (int v = 0; v < 3; v++) begin
        vr[v][0] = ((bx + $urandom_range(0, 24)) << FB) + $urandom_range(0, 255);
        vr[v][1] = ((by + $urandom_range(0, 8)) << FB) + $urandom_range(0, 255);
      end
      sc_en = ($urandom_range(0, 9) < 3);
      sc[0] = imax(bx - 4 + $urandom_range(0, 12), 0);
      sc[1] = imax(by - 2 + $urandom_range(0, 6), 0);
      sc[2] = bx + $urandom_range(0, 30);
      sc[3] = by + $urandom_range(0, 10);
      run_tri("random", 2, -1, nb_a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
